// File: rtl/morse_pkg.sv
// Shared definitions for the Morse puzzle module: sizes, sequencer states and
// the word-to-frequency answer table also used by the blinker's code table.
package morse_pkg;

   localparam int NUM_WORDS        = 16;
   localparam int IDX_W            = 4;
   localparam int CODE_W           = 16;
   localparam int DEBOUNCE_CYC_DEF = 8;
   localparam int MAX_STRIKES_DEF  = 3;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ARM,
      ST_RUN,
      ST_CHECK,
      ST_SOLVED
   } state_t;

   // Correct frequency index for each secret word.
   function automatic idx_t answer(input idx_t idx);
      case (idx)
         4'd0:    return 4'd5;
         4'd1:    return 4'd12;
         4'd2:    return 4'd2;
         4'd3:    return 4'd9;
         4'd4:    return 4'd14;
         4'd5:    return 4'd0;
         4'd6:    return 4'd7;
         4'd7:    return 4'd11;
         4'd8:    return 4'd3;
         4'd9:    return 4'd15;
         4'd10:   return 4'd1;
         4'd11:   return 4'd8;
         4'd12:   return 4'd13;
         4'd13:   return 4'd4;
         4'd14:   return 4'd10;
         default: return 4'd6;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button conditioning: two-flop synchroniser, stability counter, and a
// one-cycle pulse on each rising edge of the accepted level.
module button_debounce
   import morse_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic slow_clock,
   input  logic reset,
   input  logic btn,
   output logic evt
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic             meta;
   logic             sync;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of the others; reset is synchronous and active-low.
   always_ff @(posedge slow_clock) begin
      if (!reset) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         evt   <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
         evt  <= 1'b0;
         // Counter tracks consecutive samples that disagree with the accepted level.
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            level <= sync;
            cnt   <= '0;
            evt   <= sync;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/morse_module_ctrl.sv
// Game-level sequencer for the Morse puzzle: loads and arms the blinker, tracks
// the tuned frequency, judges transmit presses and reports strike or solve.
module morse_module_ctrl
   import morse_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int MAX_STRIKES  = MAX_STRIKES_DEF
) (
   input  logic              slow_clock,
   input  logic              reset,
   input  logic              start,
   input  logic [IDX_W-1:0]  seed,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_tx,
   output logic [CODE_W-1:0] blink_data,
   output logic              blink_set,
   output logic              blink_reset_n,
   output logic [IDX_W-1:0]  freq_idx,
   output logic              strike,
   output logic [1:0]        strike_count,
   output logic              solved,
   output logic              busy
);

   state_t state, next_state;
   idx_t   word_idx;
   logic   up_evt, down_evt, tx_evt;
   logic   correct;
   logic   accept_start;

   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
      .slow_clock(slow_clock), .reset(reset), .btn(btn_up),   .evt(up_evt)
   );
   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
      .slow_clock(slow_clock), .reset(reset), .btn(btn_down), .evt(down_evt)
   );
   button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_tx (
      .slow_clock(slow_clock), .reset(reset), .btn(btn_tx),   .evt(tx_evt)
   );

   assign correct      = (freq_idx == answer(word_idx));
   assign accept_start = start && (state == ST_IDLE || state == ST_SOLVED);

   always_ff @(posedge slow_clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      blink_set  = 1'b0;
      strike     = 1'b0;
      case (state)
         ST_IDLE:   if (start) next_state = ST_LOAD;
         ST_LOAD:   next_state = ST_ARM;
         ST_ARM: begin
            blink_set  = 1'b1;
            next_state = ST_RUN;
         end
         ST_RUN:    if (tx_evt) next_state = ST_CHECK;
         ST_CHECK: begin
            if (correct) begin
               next_state = ST_SOLVED;
            end else begin
               strike     = 1'b1;
               next_state = ST_RUN;
            end
         end
         ST_SOLVED: if (start) next_state = ST_LOAD;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Seed is captured on the accepted start edge so the word is valid throughout LOAD.
   always_ff @(posedge slow_clock) begin
      if (!reset) begin
         word_idx     <= '0;
         freq_idx     <= '0;
         strike_count <= '0;
      end else begin
         if (accept_start) begin
            word_idx <= seed;
            freq_idx <= '0;
         end else if (state == ST_RUN && !tx_evt && (up_evt ^ down_evt)) begin
            if (up_evt && freq_idx != idx_t'(NUM_WORDS - 1))
               freq_idx <= freq_idx + 1'b1;
            else if (down_evt && freq_idx != '0)
               freq_idx <= freq_idx - 1'b1;
         end
         if (state == ST_CHECK && !correct && int'(strike_count) < MAX_STRIKES)
            strike_count <= strike_count + 1'b1;
      end
   end

   assign blink_data    = {{(CODE_W - IDX_W){1'b0}}, word_idx};
   assign busy          = (state != ST_IDLE) && (state != ST_SOLVED);
   assign blink_reset_n = busy;
   assign solved        = (state == ST_SOLVED);

endmodule

// File: tb/tb_morse_module_ctrl.sv
// Scoreboarded bench for morse_module_ctrl: stimulus queues expected blinker-load,
// strike and solve events; a negedge monitor pops and compares as they appear.
module tb_morse_module_ctrl;

   logic        slow_clock = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  seed;
   logic        btn_up, btn_down, btn_tx;
   logic [15:0] blink_data;
   logic        blink_set, blink_reset_n;
   logic [3:0]  freq_idx;
   logic        strike;
   logic [1:0]  strike_count;
   logic        solved, busy;

   // Hand-computed answers for the words used here.
   localparam logic [3:0] ANS_3 = 4'd9;

   typedef enum int {EV_SET, EV_STRIKE, EV_SOLVED} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [15:0] data;
      logic [3:0]  freq;
      logic [1:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic solved_prev = 1'b0;

   morse_module_ctrl dut (
      .slow_clock   (slow_clock),
      .reset        (reset),
      .start        (start),
      .seed         (seed),
      .btn_up       (btn_up),
      .btn_down     (btn_down),
      .btn_tx       (btn_tx),
      .blink_data   (blink_data),
      .blink_set    (blink_set),
      .blink_reset_n(blink_reset_n),
      .freq_idx     (freq_idx),
      .strike       (strike),
      .strike_count (strike_count),
      .solved       (solved),
      .busy         (busy)
   );

   always #5 slow_clock = ~slow_clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input ev_kind_t k, input logic [15:0] d, input logic [3:0] f,
                       input logic [1:0] c);
      exp_t e;
      e.kind = k; e.data = d; e.freq = f; e.cnt = c;
      q.push_back(e);
   endtask

   task automatic score(input ev_kind_t k);
      exp_t e;
      if (q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
      end else begin
         e = q.pop_front();
         check("ev_kind", k, e.kind);
         check("ev_freq_idx", freq_idx, e.freq);
         check("ev_strike_count", strike_count, e.cnt);
         case (k)
            EV_SET: begin
               check("set_blink_data", blink_data, e.data);
               check("set_blink_reset_n", blink_reset_n, 1'b1);
            end
            EV_STRIKE: begin
               check("strike_solved", solved, 1'b0);
               check("strike_busy", busy, 1'b1);
            end
            default: begin
               check("solve_blink_reset_n", blink_reset_n, 1'b0);
               check("solve_busy", busy, 1'b0);
            end
         endcase
      end
   endtask

   // Monitor: every cycle an output event is present, pop and compare one record.
   always @(negedge slow_clock) begin
      if (reset) begin
         if (blink_set)              score(EV_SET);
         if (strike)                 score(EV_STRIKE);
         if (solved && !solved_prev) score(EV_SOLVED);
      end
      solved_prev = solved;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge slow_clock);
      #1;
   endtask

   task automatic press(input logic u, input logic d, input logic t, input int hold);
      btn_up = u; btn_down = d; btn_tx = t;
      cyc(hold);
      btn_up = 1'b0; btn_down = 1'b0; btn_tx = 1'b0;
      cyc(16);
   endtask

   task automatic do_start(input logic [3:0] s, input logic [1:0] cnt);
      push(EV_SET, {12'h000, s}, 4'd0, cnt);
      start = 1'b1; seed = s;
      cyc(1);
      start = 1'b0; seed = 4'hF;
      check("load_blink_data", blink_data, {12'h000, s});
      check("load_freq_idx", freq_idx, 4'd0);
      check("load_busy", busy, 1'b1);
      check("load_solved", solved, 1'b0);
      check("load_blink_set", blink_set, 1'b0);
      cyc(4);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_blink_data"}, blink_data, 16'h0000);
      check({tag, "_blink_set"}, blink_set, 1'b0);
      check({tag, "_blink_reset_n"}, blink_reset_n, 1'b0);
      check({tag, "_freq_idx"}, freq_idx, 4'd0);
      check({tag, "_strike"}, strike, 1'b0);
      check({tag, "_strike_count"}, strike_count, 2'd0);
      check({tag, "_solved"}, solved, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; start = 1'b0; seed = 4'd0;
      btn_up = 1'b0; btn_down = 1'b0; btn_tx = 1'b0;
      cyc(3);
      check_reset_state("por");
      reset = 1'b1;
      cyc(2);

      // Reset in the middle of RUN with freq_idx = 5.
      do_start(4'd3, 2'd0);
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, 14);
      check("pre_reset_freq", freq_idx, 4'd5);
      reset = 1'b0;
      cyc(1);
      check_reset_state("mid_reset");
      reset = 1'b1;
      cyc(2);
      check("idle_ignores_up", freq_idx, 4'd0);

      // Saturation and rejection of simultaneous / glitchy presses.
      do_start(4'd3, 2'd0);
      for (int i = 0; i < 20; i++) press(1'b1, 1'b0, 1'b0, 14);
      check("sat_up", freq_idx, 4'd15);
      press(1'b1, 1'b1, 1'b0, 14);
      check("both_at_top", freq_idx, 4'd15);
      for (int i = 0; i < 20; i++) press(1'b0, 1'b1, 1'b0, 14);
      check("sat_down", freq_idx, 4'd0);
      press(1'b1, 1'b0, 1'b0, 3);
      check("glitch_up", freq_idx, 4'd0);
      for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0, 14);
      check("tuned_wrong", freq_idx, ANS_3 + 4'd1);
      press(1'b1, 1'b1, 1'b0, 14);
      check("both_mid", freq_idx, 4'd10);

      // Wrong transmits; the second one coincides with an up press (tx wins).
      push(EV_STRIKE, 16'h0, 4'd10, 2'd0);
      press(1'b0, 1'b0, 1'b1, 14);
      check("strike_count_1", strike_count, 2'd1);
      push(EV_STRIKE, 16'h0, 4'd10, 2'd1);
      press(1'b1, 1'b0, 1'b1, 14);
      check("tx_wins_freq", freq_idx, 4'd10);
      check("strike_count_2", strike_count, 2'd2);
      push(EV_STRIKE, 16'h0, 4'd10, 2'd2);
      press(1'b0, 1'b0, 1'b1, 14);
      push(EV_STRIKE, 16'h0, 4'd10, 2'd3);
      press(1'b0, 1'b0, 1'b1, 14);
      push(EV_STRIKE, 16'h0, 4'd10, 2'd3);
      press(1'b0, 1'b0, 1'b1, 14);
      check("strike_count_sat", strike_count, 2'd3);
      check("still_running", busy, 1'b1);

      // Correct transmit, then presses in SOLVED are ignored.
      press(1'b0, 1'b1, 1'b0, 14);
      check("tuned_right", freq_idx, ANS_3);
      push(EV_SOLVED, 16'h0, ANS_3, 2'd3);
      press(1'b0, 1'b0, 1'b1, 14);
      check("solved_level", solved, 1'b1);
      check("solved_blink_reset_n", blink_reset_n, 1'b0);
      press(1'b1, 1'b0, 1'b0, 14);
      press(1'b0, 1'b0, 1'b1, 14);
      check("solved_freq_frozen", freq_idx, ANS_3);
      check("solved_held", solved, 1'b1);

      // Restart from SOLVED keeps the strike tally.
      do_start(4'd9, 2'd3);
      check("restart_blink_data", blink_data, 16'h0009);
      check("restart_strike_count", strike_count, 2'd3);
      check("restart_busy", busy, 1'b1);

      cyc(4);
      check("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
